pipeio_fifo_port: RTL
=====================

// Module: pipeio_fifo_port
// PURPOSE
//   Memory-mapped I/O responder for the MEM stage's I/O space (address bit 7 = 1).
//   Accepts CPU stores and queues them in a TX FIFO drained by an external device
//   over valid/ready. Captures external input words into an RX holding register.
//   Returns data and status on CPU loads.
// PARAMETERS
//   DEPTH   4   TX FIFO entries; power of two, >= 2
//   CW      3   count width = log2(DEPTH)+1
// PORTS
//   clock     in   1   single clock; all state updates on posedge
//   resetn    in   1   reset, synchronous, active-low
//   malu      in   32  byte address from MEM stage; decoded only when malu[7]=1
//   mb        in   32  store data
//   wen       in   1   store strobe, one cycle per store (mwmem & malu[7])
//   ren       in   1   load strobe, one cycle per load (read side effects)
//   rdata     out  32  load data, combinational from malu/state
//   tx_data   out  32  FIFO head word
//   tx_valid  out  1   FIFO non-empty
//   tx_ready  in   1   external device accepts head this cycle
//   rx_data   in   32  external input word
//   rx_valid  in   1   external word offered
//   rx_ready  out 1    RX holding register empty
//   irq       out  1   level interrupt (see CONFIGURATION)
// BEHAVIOUR
//   Register map (malu[7]=1; word select malu[3:2]; malu[6:4] ignored):
//     0x80 TXDATA  W: push mb. R: 0.
//     0x84 RXDATA  R: held word; with ren, clears rx_full next edge. W: ignored.
//     0x88 STATUS  R: {26'b0, ovf, rx_full, tx_full, tx_empty, count[1:0]};
//                  count saturates in 2 bits when DEPTH>4. W: ignored.
//     0x8C CTRL    R/W: bit0 rx_irq_en, bit1 txe_irq_en; write bit2=1 clears ovf.
//   If malu[7]=0: rdata=0, wen/ren ignored.
//   Reset (resetn=0 at edge): count=0, rd/wr ptr=0, rx_full=0, ovf=0, ctrl=0.
//     Outputs after reset: tx_valid=0, rx_ready=1, irq=0, tx_data = entry 0 (don't care).
//     Reset wins over any simultaneous push/pop/capture.
//   TX FIFO:
//     push = wen & TXDATA; pop = tx_valid & tx_ready.
//     Push visible on tx_valid next cycle (1-cycle latency, no bypass).
//     push&pop while full: both occur, count unchanged.
//     push&pop while empty: push only (pop impossible, tx_valid=0).
//     push while full without pop: word dropped, ovf<=1 (sticky).
//     ovf clears only via CTRL bit2 write or reset; a set and a clear in the same
//       cycle -> set wins.
//     Pointers wrap modulo DEPTH. tx_empty = (count==0). tx_full = (count==DEPTH).
//     tx_data and tx_valid stay stable until popped.
//   RX holding register:
//     rx_ready = ~rx_full. Capture = rx_valid & rx_ready -> latch word, rx_full<=1.
//     CPU pop (ren & RXDATA & rx_full): rx_full<=0; rx_ready rises next cycle.
//     ren on RXDATA while empty: returns stale word, no state change.
//     Pop and capture never coincide, since rx_ready=0 while full.
//   Loads are side-effect free except RXDATA pop. A store to a read-only
//     register has no effect.
// CONFIGURATION
//   PIPEIO_IRQ_EN defined:
//     irq = (ctrl[0] & rx_full) | (ctrl[1] & tx_empty), registered, 1-cycle lag.
//     CTRL register is implemented.
//   PIPEIO_IRQ_EN undefined:
//     irq tied 0; CTRL enable bits read 0 and writes to them are ignored.
//     CTRL bit2 (ovf clear) still functional.
// TESTING
//   1. Reset; store 0x11,0x22,0x33 to 0x80 with tx_ready=0
//      -> STATUS count=3, tx_valid=1, tx_data=0x11.
//   2. Fill FIFO (4 words); store 5th with tx_ready=0
//      -> word dropped, STATUS ovf=1, tx_full=1.
//      Write CTRL=0x4 -> ovf=0.
//   3. Full FIFO, tx_ready=1 and store 0xAA in the same cycle
//      -> count stays 4; 0xAA is drained 4th after current head.
//   4. rx_valid=1, rx_data=0xDEAD -> rx_ready=0 next cycle.
//      Load 0x84 with ren -> rdata=0xDEAD; rx_ready=1 after the edge.
//      Second load -> 0xDEAD again, rx_full stays 0.
//   5. With PIPEIO_IRQ_EN: CTRL=0x1, capture a word -> irq=1 one cycle later;
//      pop RXDATA -> irq=0.
//      Without PIPEIO_IRQ_EN -> irq stays 0 throughout.
//   6. resetn=0 for one edge while FIFO holds 2 words and tx_ready=1
//      -> count=0, tx_valid=0, rx_ready=1, ovf=0 next cycle.

Source files
------------

// File: rtl/pipeio_fifo_port_if.sv
// CPU load/store bus and external TX/RX handshakes of the MEM-stage I/O port.
// The slave modport is the port itself; master is the CPU/device side.
interface pipeio_fifo_port_if;
   logic [31:0] malu;
   logic [31:0] mb;
   logic        wen;
   logic        ren;
   logic [31:0] rdata;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;

   modport slave (
      input  malu, mb, wen, ren,
      input  tx_ready, rx_data, rx_valid,
      output rdata, tx_data, tx_valid, rx_ready
   );

   modport master (
      output malu, mb, wen, ren,
      output tx_ready, rx_data, rx_valid,
      input  rdata, tx_data, tx_valid, rx_ready
   );
endinterface

// File: rtl/pipeio_fifo_port.sv
// Memory-mapped I/O port: TX FIFO for stores, RX holding register for loads.
// Define PIPEIO_IRQ_EN to implement CTRL enables and the registered irq.
module pipeio_fifo_port #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic              clock,
   input  logic              resetn,
   pipeio_fifo_port_if.slave bus,
   output logic              irq
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   rx_word;
   logic          rx_full;
   logic          ovf;
   logic [1:0]    ctrl;
   logic [1:0]    cnt2;
   logic [1:0]    sel;
   logic          io;
   logic          tx_empty;
   logic          tx_full;
   logic          push;
   logic          pop;
   logic          do_push;
   logic          ovf_set;
   logic          ovf_clr;
   logic          ctrl_wr;
   logic          rx_pop;
   logic          capture;
   logic          unused_bits;

   assign io       = bus.malu[7];
   assign sel      = bus.malu[3:2];
   assign tx_empty = (count == '0);
   assign tx_full  = (count == CW'(DEPTH));

   // A push into a full FIFO still lands when the head leaves the same cycle
   assign push    = bus.wen & io & (sel == 2'd0);
   assign pop     = bus.tx_ready & ~tx_empty;
   assign do_push = push & (~tx_full | pop);
   assign ovf_set = push & tx_full & ~pop;
   assign ctrl_wr = bus.wen & io & (sel == 2'd3);
   assign ovf_clr = ctrl_wr & bus.mb[2];
   assign rx_pop  = bus.ren & io & (sel == 2'd1) & rx_full;
   assign capture = bus.rx_valid & ~rx_full;

   assign bus.tx_valid = ~tx_empty;
   assign bus.tx_data  = mem[rd_ptr];
   assign bus.rx_ready = ~rx_full;

   assign unused_bits = ^{bus.malu[31:8],
                          bus.malu[6:4],
                          bus.malu[1:0]};

   generate
      if (DEPTH > 4) begin : g_sat
         assign cnt2 = (count > CW'(3)) ? 2'd3
                                       : count[1:0];
      end else begin : g_raw
         assign cnt2 = count[1:0];
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (!resetn) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (do_push & ~pop)
            count <= count + CW'(1);
         else if (pop & ~do_push)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (resetn && do_push)
         mem[wr_ptr] <= bus.mb;
   end

   // ovf: a new overflow outranks a clear in the same cycle
   always_ff @(posedge clock) begin
      if (!resetn) begin
         ovf     <= 1'b0;
         rx_full <= 1'b0;
      end else begin
         if (ovf_set)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
         if (rx_pop)
            rx_full <= 1'b0;
         else if (capture)
            rx_full <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (resetn && capture)
         rx_word <= bus.rx_data;
   end

`ifdef PIPEIO_IRQ_EN
   always_ff @(posedge clock) begin
      if (!resetn) begin
         ctrl <= '0;
         irq  <= 1'b0;
      end else begin
         if (ctrl_wr)
            ctrl <= bus.mb[1:0];
         irq <= (ctrl[0] & rx_full)
              | (ctrl[1] & tx_empty);
      end
   end
`else
   assign ctrl = 2'b00;
   assign irq  = 1'b0;
`endif

   always_comb begin
      bus.rdata = '0;
      if (io) begin
         unique case (1'b1)
            sel == 2'd0: bus.rdata = '0;
            sel == 2'd1: bus.rdata = rx_word;
            sel == 2'd2: bus.rdata = {26'b0, ovf, rx_full,
                                      tx_full, tx_empty, cnt2};
            sel == 2'd3: bus.rdata = {30'b0, ctrl};
            default:     bus.rdata = '0;
         endcase
      end
   end
endmodule
